// File: rtl/clarke_pipe.sv
// Pipelined Clarke transform (abc -> alpha/beta) with a per-sample 2/3-phase mode, round-half-up and saturation.
// Latency is 3 cycles. All stages stall together while out_valid & !out_ready; in_ready = !out_valid | out_ready.
// Optional zero-sequence output when CLARKE_ZSEQ_EN is defined.
module clarke_pipe #(
    parameter int D_WIDTH = 18,
    parameter int Q_BITS  = 15,
    parameter int TAG_W   = 2
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      mode3,
    input  logic [TAG_W-1:0]          in_tag,
    input  logic signed [D_WIDTH-1:0] a,
    input  logic signed [D_WIDTH-1:0] b,
    input  logic signed [D_WIDTH-1:0] c,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [D_WIDTH-1:0] alpha,
    output logic signed [D_WIDTH-1:0] beta,
    output logic [TAG_W-1:0]          out_tag,
    output logic                      out_sat
`ifdef CLARKE_ZSEQ_EN
    ,
    output logic signed [D_WIDTH-1:0] zseq
`endif
);

    localparam int SW = D_WIDTH + 2;
    localparam int KW = Q_BITS + 2;
    localparam int PW = SW + KW;

    // Largest k with 3*(2k-1)^2 <= 4^(Q+1), i.e. round(2^Q / sqrt3), built bit by bit.
    function automatic longint calc_k1();
        longint k;
        longint t;
        longint lim;
        k   = 0;
        lim = longint'(1) << (2 * Q_BITS + 2);
        for (int i = Q_BITS; i >= 0; i--) begin
            t = k | (longint'(1) << i);
            if (3 * (2 * t - 1) * (2 * t - 1) <= lim) k = t;
        end
        return k;
    endfunction

    localparam logic signed [KW-1:0] K1      = KW'(calc_k1());
    localparam logic signed [KW-1:0] K3      = KW'(((longint'(1) << (Q_BITS + 1)) + 3) / 6);
    localparam logic signed [KW-1:0] ONE_Q   = KW'(longint'(1) << Q_BITS);
    localparam logic signed [PW-1:0] HALF    = PW'(1) << (Q_BITS - 1);
    localparam logic signed [PW-1:0] SAT_MAX = (PW'(1) << (D_WIDTH - 1)) - PW'(1);
    localparam logic signed [PW-1:0] SAT_MIN = -(PW'(1) << (D_WIDTH - 1));

    function automatic logic [D_WIDTH:0] rnd_sat(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] r;
        r = (p + HALF) >>> Q_BITS;
        if (r > SAT_MAX)      rnd_sat = {1'b1, SAT_MAX[D_WIDTH-1:0]};
        else if (r < SAT_MIN) rnd_sat = {1'b1, SAT_MIN[D_WIDTH-1:0]};
        else                  rnd_sat = {1'b0, r[D_WIDTH-1:0]};
    endfunction

    logic adv;
    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;

    logic signed [SW-1:0] ae, be, ce;
    logic signed [SW-1:0] sum_al, sum_be;
    assign ae = {{2{a[D_WIDTH-1]}}, a};
    assign be = {{2{b[D_WIDTH-1]}}, b};
    assign ce = {{2{c[D_WIDTH-1]}}, c};
    assign sum_al = mode3 ? (ae + ae - be - ce) : ae;
    assign sum_be = mode3 ? (be - ce) : (ae + be + be);

    // Stage 1: sums, mode and tag
    logic                 s1_vld, s1_mode;
    logic [TAG_W-1:0]     s1_tag;
    logic signed [SW-1:0] s1_al, s1_be;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            s1_vld  <= 1'b0;
            s1_mode <= 1'b0;
            s1_tag  <= '0;
            s1_al   <= '0;
            s1_be   <= '0;
        end else if (adv) begin
            s1_vld  <= in_valid;
            s1_mode <= mode3;
            s1_tag  <= in_tag;
            s1_al   <= sum_al;
            s1_be   <= sum_be;
        end
    end

    // 2-phase alpha goes through the same multiplier scaled by 2^Q, so rounding returns a exactly.
    logic signed [KW-1:0] k_al;
    logic signed [PW-1:0] p_al, p_be;
    assign k_al = s1_mode ? K3 : ONE_Q;
    assign p_al = PW'(s1_al) * PW'(k_al);
    assign p_be = PW'(s1_be) * PW'(K1);

    // Stage 2: full-precision products
    logic                 s2_vld;
    logic [TAG_W-1:0]     s2_tag;
    logic signed [PW-1:0] s2_al, s2_be;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            s2_vld <= 1'b0;
            s2_tag <= '0;
            s2_al  <= '0;
            s2_be  <= '0;
        end else if (adv) begin
            s2_vld <= s1_vld;
            s2_tag <= s1_tag;
            s2_al  <= p_al;
            s2_be  <= p_be;
        end
    end

    logic                      sat_al, sat_be, sat_z;
    logic signed [D_WIDTH-1:0] al_nx, be_nx;
    assign {sat_al, al_nx} = rnd_sat(s2_al);
    assign {sat_be, be_nx} = rnd_sat(s2_be);

`ifdef CLARKE_ZSEQ_EN
    logic signed [SW-1:0]      s1_z;
    logic signed [PW-1:0]      s2_z;
    logic signed [D_WIDTH-1:0] z_nx;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            s1_z <= '0;
            s2_z <= '0;
            zseq <= '0;
        end else if (adv) begin
            s1_z <= mode3 ? (ae + be + ce) : '0;
            s2_z <= PW'(s1_z) * PW'(K3);
            if (s2_vld) zseq <= z_nx;
        end
    end

    assign {sat_z, z_nx} = rnd_sat(s2_z);
`else
    assign sat_z = 1'b0;
`endif

    // Stage 3: round, saturate, present; data only changes when a real sample lands
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            out_valid <= 1'b0;
            alpha     <= '0;
            beta      <= '0;
            out_tag   <= '0;
            out_sat   <= 1'b0;
        end else if (adv) begin
            out_valid <= s2_vld;
            if (s2_vld) begin
                alpha   <= al_nx;
                beta    <= be_nx;
                out_tag <= s2_tag;
                out_sat <= sat_al | sat_be | sat_z;
            end
        end
    end

endmodule

// File: tb/tb_clarke_pipe.sv
// Directed and randomised checks of clarke_pipe at D_WIDTH=18, Q_BITS=15, TAG_W=2.
module tb_clarke_pipe;

    logic               clk = 1'b0;
    logic               rstb;
    logic               in_valid, in_ready, mode3, out_valid, out_ready, out_sat;
    logic [1:0]         in_tag, out_tag;
    logic signed [17:0] a, b, c, alpha, beta, zseq;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    clarke_pipe #(.D_WIDTH(18), .Q_BITS(15), .TAG_W(2)) dut (
        .clk(clk), .rstb(rstb),
        .in_valid(in_valid), .in_ready(in_ready), .mode3(mode3), .in_tag(in_tag),
        .a(a), .b(b), .c(c),
        .out_valid(out_valid), .out_ready(out_ready),
        .alpha(alpha), .beta(beta), .out_tag(out_tag), .out_sat(out_sat)
`ifdef CLARKE_ZSEQ_EN
        , .zseq(zseq)
`endif
    );

`ifndef CLARKE_ZSEQ_EN
    assign zseq = '0;
`endif

    typedef struct {
        logic signed [17:0] al;
        logic signed [17:0] be;
        logic signed [17:0] z;
        logic [1:0]         tag;
        logic               sat;
    } exp_t;

    function automatic logic [18:0] model_rs(input longint p);
        longint r;
        r = (p + 16384) >>> 15;
        if (r > 131071)       model_rs = {1'b1, 18'h1FFFF};
        else if (r < -131072) model_rs = {1'b1, 18'h20000};
        else                  model_rs = {1'b0, r[17:0]};
    endfunction

    function automatic exp_t model(input logic m, input logic signed [17:0] va, input logic signed [17:0] vb,
                                   input logic signed [17:0] vc, input logic [1:0] t);
        longint la, lb, lc;
        logic [18:0] ra, rb, rz;
        la = va; lb = vb; lc = vc;
        if (m) begin
            ra = model_rs((2 * la - lb - lc) * 10923);
            rb = model_rs((lb - lc) * 18919);
            rz = model_rs((la + lb + lc) * 10923);
        end else begin
            ra = {1'b0, va};
            rb = model_rs((la + 2 * lb) * 18919);
            rz = 19'd0;
        end
        model.al  = ra[17:0];
        model.be  = rb[17:0];
        model.z   = rz[17:0];
        model.tag = t;
`ifdef CLARKE_ZSEQ_EN
        model.sat = ra[18] | rb[18] | rz[18];
`else
        model.sat = ra[18] | rb[18];
`endif
    endfunction

    // Sends one sample into an empty pipeline and returns #1 after the edge where it should appear.
    task automatic drive_single(input logic m, input logic signed [17:0] va, input logic signed [17:0] vb,
                                input logic signed [17:0] vc, input logic [1:0] t, output logic early_vld);
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid = 1'b1; mode3 = m; a = va; b = vb; c = vc; in_tag = t;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        early_vld = out_valid;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rstb = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mode3 = 1'b0; in_tag = '0;
        a = '0; b = '0; c = '0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests++; if (alpha !== 18'sd0) begin fails++; $display("FAIL reset_alpha got %0d want 0", alpha); end
        tests++; if (beta !== 18'sd0) begin fails++; $display("FAIL reset_beta got %0d want 0", beta); end
        tests++; if (out_tag !== 2'd0) begin fails++; $display("FAIL reset_tag got %0d want 0", out_tag); end
        tests++; if (out_sat !== 1'b0) begin fails++; $display("FAIL reset_sat got %b want 0", out_sat); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        tests++; if (zseq !== 18'sd0) begin fails++; $display("FAIL reset_zseq got %0d want 0", zseq); end
        @(negedge clk);
        rstb = 1'b1;
    endtask

    task automatic test_two_phase();
        logic ev;
        drive_single(1'b0, 18'sd16384, 18'sd0, 18'sd777, 2'd2, ev);
        tests++; if (ev !== 1'b0) begin fails++; $display("FAIL p2_early got %b want 0", ev); end
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL p2_valid got %b want 1", out_valid); end
        tests++; if (alpha !== 18'sd16384) begin fails++; $display("FAIL p2_alpha got %0d want 16384", alpha); end
        tests++; if (beta !== 18'sd9460) begin fails++; $display("FAIL p2_beta got %0d want 9460", beta); end
        tests++; if (out_sat !== 1'b0) begin fails++; $display("FAIL p2_sat got %b want 0", out_sat); end
        tests++; if (out_tag !== 2'd2) begin fails++; $display("FAIL p2_tag got %0d want 2", out_tag); end
        tests++; if (zseq !== 18'sd0) begin fails++; $display("FAIL p2_zseq got %0d want 0", zseq); end
    endtask

    task automatic test_three_phase();
        logic ev;
        drive_single(1'b1, 18'sd16384, -18'sd8192, -18'sd8192, 2'd1, ev);
        tests++; if (ev !== 1'b0) begin fails++; $display("FAIL p3_early got %b want 0", ev); end
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL p3_valid got %b want 1", out_valid); end
        tests++; if (alpha !== 18'sd16385) begin fails++; $display("FAIL p3_alpha got %0d want 16385", alpha); end
        tests++; if (beta !== 18'sd0) begin fails++; $display("FAIL p3_beta got %0d want 0", beta); end
        tests++; if (out_sat !== 1'b0) begin fails++; $display("FAIL p3_sat got %b want 0", out_sat); end
        tests++; if (out_tag !== 2'd1) begin fails++; $display("FAIL p3_tag got %0d want 1", out_tag); end
        tests++; if (zseq !== 18'sd0) begin fails++; $display("FAIL p3_zseq got %0d want 0", zseq); end
    endtask

    task automatic test_saturation();
        logic ev;
        drive_single(1'b0, 18'sd131071, 18'sd131071, 18'sd0, 2'd0, ev);
        tests++; if (alpha !== 18'sd131071) begin fails++; $display("FAIL satp_alpha got %0d want 131071", alpha); end
        tests++; if (beta !== 18'sd131071) begin fails++; $display("FAIL satp_beta got %0d want 131071", beta); end
        tests++; if (out_sat !== 1'b1) begin fails++; $display("FAIL satp_flag got %b want 1", out_sat); end
        drive_single(1'b0, -18'sd131072, -18'sd131072, 18'sd0, 2'd3, ev);
        tests++; if (alpha !== -18'sd131072) begin fails++; $display("FAIL satn_alpha got %0d want -131072", alpha); end
        tests++; if (beta !== -18'sd131072) begin fails++; $display("FAIL satn_beta got %0d want -131072", beta); end
        tests++; if (out_sat !== 1'b1) begin fails++; $display("FAIL satn_flag got %b want 1", out_sat); end
        // alpha path saturation in 3-phase: 2a-b-c = 524286 -> 174762 before clamping
        drive_single(1'b1, 18'sd131071, -18'sd131072, -18'sd131072, 2'd1, ev);
        tests++; if (alpha !== 18'sd131071) begin fails++; $display("FAIL sat3_alpha got %0d want 131071", alpha); end
        tests++; if (beta !== 18'sd0) begin fails++; $display("FAIL sat3_beta got %0d want 0", beta); end
        tests++; if (out_sat !== 1'b1) begin fails++; $display("FAIL sat3_flag got %b want 1", out_sat); end
        drive_single(1'b0, 18'sd1000, 18'sd0, 18'sd0, 2'd2, ev);
        tests++; if (out_sat !== 1'b0) begin fails++; $display("FAIL sat_clear got %b want 0", out_sat); end
        tests++; if (beta !== 18'sd577) begin fails++; $display("FAIL sat_clear_beta got %0d want 577", beta); end
    endtask

    task automatic test_backpressure();
        logic signed [17:0] ea;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int t = 0; t < 3; t++) begin
            in_valid = 1'b1; mode3 = 1'b0; in_tag = 2'(t);
            a = 18'(100 * (t + 1)); b = '0; c = '0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            tests++;
            if (out_valid !== 1'b1 || out_tag !== 2'd0 || alpha !== 18'sd100 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold got vld=%b tag=%0d alpha=%0d rdy=%b want vld=1 tag=0 alpha=100 rdy=0",
                         out_valid, out_tag, alpha, in_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_rdy got %b want 1", in_ready); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ea = 18'(100 * (k + 1));
            tests++;
            if (out_valid !== 1'b1 || out_tag !== 2'(k) || alpha !== ea) begin
                fails++;
                $display("FAIL bp_drain%0d got vld=%b tag=%0d alpha=%0d want vld=1 tag=%0d alpha=%0d",
                         k, out_valid, out_tag, alpha, k, ea);
            end
        end
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_empty got %b want 0", out_valid); end
    endtask

    task automatic test_random_stream();
        exp_t               q[$];
        exp_t               e;
        logic signed [17:0] va[100], vb[100], vc[100];
        int                 idx = 0;
        int                 got = 0;
        int                 cyc = 0;
        logic               acc = 1'b0;
        for (int i = 0; i < 100; i++) begin
            va[i] = 18'($urandom); vb[i] = 18'($urandom); vc[i] = 18'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                va[i] = va[i] >>> 5; vb[i] = vb[i] >>> 5; vc[i] = vc[i] >>> 5;
            end
        end
        @(posedge clk); #1;
        while (got < 100 && cyc < 2000) begin
            if (acc) idx++;
            acc = 1'b0;
            out_ready = ($urandom_range(0, 3) != 0);
            if (idx < 100) begin
                in_valid = 1'b1; mode3 = idx[0]; in_tag = idx[1:0];
                a = va[idx]; b = vb[idx]; c = vc[idx];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                q.push_back(model(mode3, a, b, c, in_tag));
                acc = 1'b1;
            end
            if (out_valid && out_ready) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL rand_extra got unexpected output tag=%0d want none", out_tag);
                end else begin
                    e = q.pop_front();
                    if (alpha !== e.al || beta !== e.be || out_tag !== e.tag || out_sat !== e.sat
`ifdef CLARKE_ZSEQ_EN
                        || zseq !== e.z
`endif
                    ) begin
                        fails++;
                        $display("FAIL rand_out%0d got al=%0d be=%0d tag=%0d sat=%b z=%0d want al=%0d be=%0d tag=%0d sat=%b z=%0d",
                                 got, alpha, beta, out_tag, out_sat, zseq, e.al, e.be, e.tag, e.sat, e.z);
                    end
                end
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        tests++; if (got != 100) begin fails++; $display("FAIL rand_count got %0d want 100", got); end
        tests++; if (q.size() != 0) begin fails++; $display("FAIL rand_leftover got %0d want 0", q.size()); end
    endtask

    task automatic test_reset_midflight();
        logic seen;
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            in_valid = 1'b1; mode3 = 1'b0; in_tag = 2'd3; a = 18'sd5000; b = 18'sd300; c = '0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rst_pre_valid got %b want 1", out_valid); end
        #1 rstb = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b want 0", out_valid); end
        tests++; if (alpha !== 18'sd0 || out_tag !== 2'd0) begin
            fails++; $display("FAIL rst_data got alpha=%0d tag=%0d want 0 0", alpha, out_tag);
        end
        @(negedge clk);
        rstb = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL rst_after got out_valid=1 want 0"); end
    endtask

    initial begin
        test_reset();
        test_two_phase();
        test_three_phase();
        test_saturation();
        test_backpressure();
        test_random_stream();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
